// File: rtl/program_memory_pkg.sv
// rtl/program_memory_pkg.sv - shared constants and loader state type for program_memory
// Purpose : default widths, the fill word returned for unloaded/out-of-range fetches,
//           and the byte-loader FSM state encoding.
package program_memory_pkg;

   localparam int INSTR_WIDTH_DEF = 16;
   localparam int PC_WIDTH_DEF    = 8;

   localparam logic [INSTR_WIDTH_DEF-1:0] INSTR_FILL = '0;

   typedef enum logic [1:0] {
      LOAD_HI = 2'd0,
      LOAD_LO = 2'd1,
      RUN     = 2'd2,
      ERROR   = 2'd3
   } pmem_state_t;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - single-write-port, single-synchronous-read-port instruction RAM
// Purpose : block-RAM-inferable storage, contents deliberately not reset.
// Ports   : clk_i      - clock
//           we_i       - write enable
//           waddr_i    - write address
//           wdata_i    - write data
//           raddr_i    - read address, data appears on rdata_o after the next rising edge
//           rdata_o    - registered read data
module imem_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // No reset on the array or the read register so the tools map this onto block RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/program_memory.sv
// rtl/program_memory.sv - byte-stream loaded program memory with CPU hold and fetch port
// Purpose : assembles big-endian byte pairs into instruction words, stores them in
//           imem_ram, then serves registered fetches while holding the CPU in reset
//           until a complete, well-formed program is present.
// Ports   : clk, reset_n                  - clock, asynchronous active-low reset
//           load_data/valid/last/ready    - byte load stream (high byte first)
//           reload                        - discard program and restart loading (RUN/ERROR)
//           pc, instruction               - fetch address in, word out one cycle later
//           cpu_hold, loaded, load_error  - status
//           word_count                    - words loaded so far
module program_memory
   import program_memory_pkg::*;
#(
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int PC_WIDTH    = PC_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             load_data,
   input  logic                   load_valid,
   input  logic                   load_last,
   output logic                   load_ready,
   input  logic                   reload,
   input  logic [PC_WIDTH-1:0]    pc,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   cpu_hold,
   output logic                   loaded,
   output logic                   load_error,
   output logic [PC_WIDTH:0]      word_count
);

   localparam logic [INSTR_WIDTH-1:0] FILL_WORD = INSTR_WIDTH'(INSTR_FILL);
   localparam logic [PC_WIDTH:0]      WC_ONE    = {{PC_WIDTH{1'b0}}, 1'b1};

   pmem_state_t            state_q, state_d;
   logic [7:0]             hi_q, hi_d;
   logic [PC_WIDTH:0]      word_count_q, word_count_d;
   logic                   rd_valid_q;

   logic                   transfer;
   logic                   ram_we;
   logic [INSTR_WIDTH-1:0] ram_rdata;

   assign load_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
   assign transfer   = load_valid && load_ready;

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      word_count_d = word_count_q;
      ram_we       = 1'b0;
      unique case (state_q)
         LOAD_HI: begin
            if (transfer) begin
               // The MSB of word_count set means the array is already full.
               if (word_count_q[PC_WIDTH] || load_last) begin
                  state_d = ERROR;
               end else begin
                  hi_d    = load_data;
                  state_d = LOAD_LO;
               end
            end
         end
         LOAD_LO: begin
            if (transfer) begin
               ram_we       = reset_n;
               word_count_d = word_count_q + WC_ONE;
               state_d      = load_last ? RUN : LOAD_HI;
            end
         end
         RUN, ERROR: begin
            if (reload) begin
               state_d      = LOAD_HI;
               word_count_d = '0;
            end
         end
         default: state_d = LOAD_HI;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= LOAD_HI;
         hi_q         <= '0;
         word_count_q <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         word_count_q <= word_count_d;
         // Tracks whether the word now being read lies inside the loaded program,
         // so stale words from an earlier, longer program are never exposed.
         rd_valid_q   <= ({1'b0, pc} < word_count_q);
      end
   end

   imem_ram #(
      .ADDR_WIDTH (PC_WIDTH),
      .DATA_WIDTH (INSTR_WIDTH)
   ) u_imem_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (word_count_q[PC_WIDTH-1:0]),
      .wdata_i (INSTR_WIDTH'({hi_q, load_data})),
      .raddr_i (pc),
      .rdata_o (ram_rdata)
   );

   // Gating on the current state makes the fill word appear the cycle a reload lands.
   assign instruction = ((state_q == RUN) && rd_valid_q) ? ram_rdata : FILL_WORD;
   assign cpu_hold    = (state_q != RUN);
   assign loaded      = (state_q == RUN);
   assign load_error  = (state_q == ERROR);
   assign word_count  = word_count_q;

endmodule

// File: tb/tb_program_memory.sv
// tb/tb_program_memory.sv - self-checking bench for program_memory
module tb_program_memory;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  load_data = '0;
   logic        load_valid = 1'b0;
   logic        load_last = 1'b0;
   logic        load_ready;
   logic        reload = 1'b0;
   logic [1:0]  pc = '0;
   logic [15:0] instruction;
   logic        cpu_hold;
   logic        loaded;
   logic        load_error;
   logic [2:0]  word_count;

   int n_checks = 0;
   int n_fail   = 0;

   program_memory #(
      .INSTR_WIDTH (16),
      .PC_WIDTH    (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .reload      (reload),
      .pc          (pc),
      .instruction (instruction),
      .cpu_hold    (cpu_hold),
      .loaded      (loaded),
      .load_error  (load_error),
      .word_count  (word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        v;
      logic        l;
      logic        r;
      logic [1:0]  p;
      logic        e_rdy;
      logic        e_hold;
      logic        e_ld;
      logic        e_err;
      logic [2:0]  e_wc;
      logic [15:0] e_instr;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_status(input string tag, input logic rdy, input logic hold,
                             input logic ld, input logic err, input logic [2:0] wc);
      chk({tag, ".load_ready"}, {31'd0, load_ready}, {31'd0, rdy});
      chk({tag, ".cpu_hold"},   {31'd0, cpu_hold},   {31'd0, hold});
      chk({tag, ".loaded"},     {31'd0, loaded},     {31'd0, ld});
      chk({tag, ".load_error"}, {31'd0, load_error}, {31'd0, err});
      chk({tag, ".word_count"}, {29'd0, word_count}, {29'd0, wc});
   endtask

   // Inputs are driven 1 time unit after a rising edge and outputs sampled at the same point.
   task automatic step(input logic [7:0] d, input logic v, input logic l,
                       input logic r, input logic [1:0] p);
      load_data  = d;
      load_valid = v;
      load_last  = l;
      reload     = r;
      pc         = p;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
      reload     = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      step(d, 1'b1, l, 1'b0, pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Loads 12 34 56 78, fetches, reload, odd-length error, valid gap, reload-in-load.
      vq.push_back('{8'h12,1'b1,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'h34,1'b1,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd1,16'h0000});
      vq.push_back('{8'h56,1'b1,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd1,16'h0000});
      vq.push_back('{8'h78,1'b1,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b1,1'b0,3'd2,16'h1234});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd1, 1'b0,1'b0,1'b1,1'b0,3'd2,16'h5678});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd2, 1'b0,1'b0,1'b1,1'b0,3'd2,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd3, 1'b0,1'b0,1'b1,1'b0,3'd2,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd0, 1'b0,1'b0,1'b1,1'b0,3'd2,16'h1234});
      vq.push_back('{8'h00,1'b0,1'b0,1'b1,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'hAB,1'b1,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'hCD,1'b1,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd1,16'h0000});
      vq.push_back('{8'hEF,1'b1,1'b1,1'b0,2'd0, 1'b0,1'b1,1'b0,1'b1,3'd1,16'h0000});
      vq.push_back('{8'hFF,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b1,1'b0,1'b1,3'd1,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd0, 1'b0,1'b1,1'b0,1'b1,3'd1,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b1,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'h9A,1'b1,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'hBC,1'b1,1'b1,1'b0,2'd3, 1'b0,1'b0,1'b1,1'b0,3'd1,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd0, 1'b0,1'b0,1'b1,1'b0,3'd1,16'h9ABC});
      vq.push_back('{8'h00,1'b0,1'b0,1'b1,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b1,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'h11,1'b1,1'b0,1'b1,2'd0, 1'b1,1'b1,1'b0,1'b0,3'd0,16'h0000});
      vq.push_back('{8'h22,1'b1,1'b1,1'b1,2'd1, 1'b0,1'b0,1'b1,1'b0,3'd1,16'h0000});
      vq.push_back('{8'h00,1'b0,1'b0,1'b0,2'd0, 1'b0,1'b0,1'b1,1'b0,3'd1,16'h1122});

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk_status("reset", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      chk("reset.instruction", {16'd0, instruction}, 32'h0);
      reset_n = 1'b1;
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
      chk_status("post_reset", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

      foreach (vq[i]) begin
         step(vq[i].d, vq[i].v, vq[i].l, vq[i].r, vq[i].p);
         chk($sformatf("vec%0d", i), {load_ready, cpu_hold, loaded, load_error},
             {vq[i].e_rdy, vq[i].e_hold, vq[i].e_ld, vq[i].e_err});
         chk($sformatf("vec%0d.word_count", i), {29'd0, word_count}, {29'd0, vq[i].e_wc});
         chk($sformatf("vec%0d.instruction", i), {16'd0, instruction}, {16'd0, vq[i].e_instr});
      end

      // Reload while fetching pc=1: fill word and hold on the very next cycle.
      step(8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
      send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0); send(8'hD4, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
      chk("rl.pre_instr", {16'd0, instruction}, 32'hC3D4);
      step(8'h00, 1'b0, 1'b0, 1'b1, 2'd1);
      chk("rl.instr", {16'd0, instruction}, 32'h0);
      chk_status("rl", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      send(8'hF0, 1'b0); send(8'h0D, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
      chk("rl.overwrite", {16'd0, instruction}, 32'hF00D);
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
      chk("rl.stale_masked", {16'd0, instruction}, 32'h0);

      // Overflow: four words fit, the 9th byte errors with nothing written.
      step(8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
      for (int b = 1; b <= 8; b++) send(8'(b), 1'b0);
      chk_status("ovf.full", 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
      send(8'h09, 1'b0);
      chk_status("ovf.err", 1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd3);
      chk("ovf.err_instr", {16'd0, instruction}, 32'h0);
      step(8'h00, 1'b0, 1'b0, 1'b1, 2'd3);
      chk_status("ovf.reload", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      for (int b = 1; b <= 8; b++) send(8'(8'h11 * b), (b == 8));
      chk_status("ovf.run", 1'b0, 1'b0, 1'b1, 1'b0, 3'd4);
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd3);
      chk("ovf.word3", {16'd0, instruction}, 32'h7788);
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd2);
      chk("ovf.word2", {16'd0, instruction}, 32'h5566);

      // Asynchronous reset between hi and lo byte of word 1.
      step(8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      chk_status("arst.during", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      chk("arst.instr", {16'd0, instruction}, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk_status("arst.after", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      send(8'h9A, 1'b0); send(8'hBC, 1'b1);
      chk_status("arst.run", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
      chk("arst.word0", {16'd0, instruction}, 32'h9ABC);
      step(8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
      chk("arst.word1_masked", {16'd0, instruction}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
